gate_vector_checker: RTL and testbench
======================================

// Module: gate_vector_checker
// PURPOSE
//   Downstream scoreboard for gate_design. Consumes one {a,b} vector plus the DUT's
//   and_out/or_out/xor_out per handshake and compares them with golden AND/OR/XOR.
//   Counts vectors and mismatches, captures the first failure, and reports pass/done
//   after NUM_VECTORS vectors. Replaces ad-hoc $display checking with synthesizable self-check.
// PARAMETERS
//   NUM_VECTORS  4   vectors per run; must be >= 1 and < 2**CNT_W
//   CNT_W        16  width of vec_count, err_count, first_fail_idx
// PORTS
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous, active-low reset
//   start           in   1      single-cycle run request
//   in_valid        in   1      vector + DUT outputs are presented
//   in_ready        out  1      checker accepts this cycle
//   a, b            in   1      inputs that were applied to gate_design
//   and_out         in   1      DUT AND result
//   or_out          in   1      DUT OR result
//   xor_out         in   1      DUT XOR result
//   busy            out  1      run in progress (state RUN)
//   done            out  1      run complete; held until next start
//   pass            out  1      done && err_count==0
//   vec_count       out  CNT_W  vectors accepted this run
//   err_count       out  CNT_W  vectors with >=1 mismatching gate; saturates at all-ones
//   fail_mask       out  3      sticky {and,or,xor} mismatch flags for this run
//   first_fail_idx  out  CNT_W  vec_count value (0-based) of first failing vector
//   first_fail_vec  out  5      {a,b,and_out,or_out,xor_out} of first failing vector
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; every output 0 (first_fail_* 0, pass 0).
//   FSM: IDLE -start-> RUN; RUN -accept of vector NUM_VECTORS-> DONE; DONE -start-> RUN.
//     start in RUN is ignored. start in IDLE/DONE clears all counters, fail_mask,
//     first_fail_*, done, on the same edge it enters RUN.
//   Handshake: in_ready = (state==RUN), combinational from state only. Accept = in_valid &&
//     in_ready on a rising edge. in_valid outside RUN is ignored; nothing is counted.
//   Per accept, same edge (results visible the next cycle):
//     exp = {a&b, a|b, a^b}; mis = exp ^ {and_out,or_out,xor_out}.
//     vec_count += 1; fail_mask |= mis; if |mis, err_count += 1 (no wrap at max).
//     If |mis and this is the first failure of the run, then first_fail_idx = vec_count
//     (pre-increment) and first_fail_vec = inputs; otherwise both hold.
//   The accept that makes vec_count==NUM_VECTORS moves to DONE on that edge.
//     done=1, busy=0 and in_ready=0 from the next cycle. pass = done && (err_count==0).
//   Latency: 1 cycle from accept to counter/flag update. No bubbles: back-to-back
//     accepts every cycle are supported.
//   Simultaneous start + in_valid in IDLE/DONE: the vector is not accepted (in_ready=0).
//   Reset mid-run: everything clears immediately; no partial report survives.
//   X/Z on inputs: not modelled; the bench drives known values.
// STRUCTURE
//   gate_check_pkg: state enum {ST_IDLE, ST_RUN, ST_DONE} (2-bit), bit-index constants
//     IDX_AND=2, IDX_OR=1, IDX_XOR=0, and the width constant FAIL_VEC_W=5.
//   Sub-module gate_golden: combinational a,b -> {and,or,xor} expected. It is reused
//     later by the stimulus generator.
//   Top holds the FSM, counters with saturation, and first-fail capture registers.
// TESTING
//   1 Reset: hold rst_n=0 with in_valid=1 and start=1 -> all outputs 0, in_ready=0.
//   2 Clean run: start, then 4 back-to-back correct vectors 00,01,10,11 -> vec_count=4,
//     err_count=0, fail_mask=000, done=1, pass=1 one cycle after the 4th accept.
//   3 Single fault: vector index 2 (a=1,b=0) with xor_out=0 -> err_count=1, fail_mask=001,
//     first_fail_idx=2, first_fail_vec=5'b10010, pass=0.
//   4 Multi fault: vec 1 with and_out=1, vec 3 with or_out=0 -> err_count=2,
//     fail_mask=110, first_fail_idx=1, first_fail_vec=5'b01111.
//   5 Control edges: start mid-run is ignored (count continues); in_valid gaps stall
//     counting; start in DONE clears counters and starts a new run; in_valid in DONE
//     changes nothing.
//   6 Async reset after vector 2 of 4 -> immediate clear; a new start gives a fresh run.
//     Optional: CNT_W=2, NUM_VECTORS=3, all vectors faulty -> err_count=3 and holds.

Source files
------------

// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the gate_design scoreboard.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit positions inside the 3-bit {and,or,xor} result vector.
  localparam int IDX_AND = 2;
  localparam int IDX_OR  = 1;
  localparam int IDX_XOR = 0;

  // Width of the captured {a,b,and_out,or_out,xor_out} record.
  localparam int FAIL_VEC_W = 5;

endpackage

// File: rtl/gate_vector_checker_golden.sv
// Golden reference for the basic gates: a,b -> {and,or,xor}.
module gate_golden
  import gate_check_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [2:0] exp_out
);

  // Pure combinational truth table of the three gates.
  always_comb begin
    exp_out          = '0;
    exp_out[IDX_AND] = a & b;
    exp_out[IDX_OR]  = a | b;
    exp_out[IDX_XOR] = a ^ b;
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Scoreboard for gate_design: counts vectors and mismatches, records the
// first failure and reports done/pass after NUM_VECTORS accepted vectors.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  a,
  input  logic                  b,
  input  logic                  and_out,
  input  logic                  or_out,
  input  logic                  xor_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [2:0]            fail_mask,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [FAIL_VEC_W-1:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS - 1);

  state_e     state;
  logic [2:0] exp_bits;
  logic [2:0] dut_bits;
  logic [2:0] mis;
  logic       accept;
  logic       any_mis;
  logic       launch;
  logic       last_vec;

  gate_golden u_golden (
    .a       (a),
    .b       (b),
    .exp_out (exp_bits)
  );

  // Pack the DUT results in the same bit order as the golden vector.
  always_comb begin
    dut_bits          = '0;
    dut_bits[IDX_AND] = and_out;
    dut_bits[IDX_OR]  = or_out;
    dut_bits[IDX_XOR] = xor_out;
  end

  assign in_ready = (state == ST_RUN);
  assign accept   = in_valid & in_ready;
  assign mis      = exp_bits ^ dut_bits;
  assign any_mis  = |mis;
  // start only launches a run from IDLE/DONE; in RUN it is ignored.
  assign launch   = start & (state != ST_RUN);
  assign last_vec = (vec_count == CNT_LAST);
  assign pass     = done & (err_count == '0);

  // Run-control FSM with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state <= ST_RUN;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        ST_RUN: if (accept && last_vec) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Counters, sticky mask and first-failure capture; cleared on run launch.
  // err_count==0 before an accept identifies the first failure of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count      <= '0;
      err_count      <= '0;
      fail_mask      <= '0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (launch) begin
      vec_count      <= '0;
      err_count      <= '0;
      fail_mask      <= '0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else if (accept) begin
      vec_count <= vec_count + CNT_ONE;
      fail_mask <= fail_mask | mis;
      if (any_mis) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
        if (err_count == '0) begin
          first_fail_idx <= vec_count;
          first_fail_vec <= {a, b, and_out, or_out, xor_out};
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized and directed checks of gate_vector_checker against a
// behavioural scoreboard model.
module tb_gate_vector_checker;
  localparam int NV = 4;
  localparam int CW = 16;
  localparam int SW = 4 + 3 * CW + 3 + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0;
  logic          and_out = 1'b0, or_out = 1'b0, xor_out = 1'b0;
  logic          in_ready, busy, done, pass;
  logic [CW-1:0] vec_count, err_count, first_fail_idx;
  logic [2:0]    fail_mask;
  logic [4:0]    first_fail_vec;

  int checks = 0;
  int failures = 0;

  // model: run status flags and report contents
  bit       m_run, m_done;
  int       m_vec, m_err;
  bit [2:0] m_mask;
  int       m_ffi;
  bit [4:0] m_ffv;

  gate_vector_checker #(.NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .and_out(and_out), .or_out(or_out),
    .xor_out(xor_out), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .fail_mask(fail_mask),
    .first_fail_idx(first_fail_idx), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] dut_snap();
    return {busy, done, pass, in_ready, vec_count, err_count, fail_mask,
            first_fail_idx, first_fail_vec};
  endfunction

  function automatic logic [SW-1:0] exp_snap();
    return {m_run, m_done, m_done && m_err == 0, m_run, CW'(m_vec), CW'(m_err),
            m_mask, CW'(m_ffi), m_ffv};
  endfunction

  function automatic void model_clear();
    m_vec = 0; m_err = 0; m_mask = 0; m_ffi = 0; m_ffv = 0;
  endfunction

  // One clock: drive inputs, advance the model, sample 1ns after the edge.
  task automatic cyc(input bit s, input bit v, input bit ia, input bit ib,
                     input bit ao, input bit oo, input bit xo);
    bit [2:0] mis;
    start = s; in_valid = v; a = ia; b = ib;
    and_out = ao; or_out = oo; xor_out = xo;
    if (m_run) begin
      if (v) begin
        mis = {ia & ib, ia | ib, ia ^ ib} ^ {ao, oo, xo};
        if (mis != 0) begin
          if (m_err == 0) begin m_ffi = m_vec; m_ffv = {ia, ib, ao, oo, xo}; end
          if (m_err < (1 << CW) - 1) m_err++;
        end
        m_mask |= mis;
        m_vec++;
        if (m_vec == NV) begin m_run = 0; m_done = 1; end
      end
    end else if (s) begin
      model_clear(); m_run = 1; m_done = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic good(input bit v, input bit ia, input bit ib);
    cyc(1'b0, v, ia, ib, ia & ib, ia | ib, ia ^ ib);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; in_valid = 0;
    model_clear(); m_run = 0; m_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    model_clear(); m_run = 0; m_done = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_snap() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", dut_snap());
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    start = 0; in_valid = 0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_run();
    do_reset();
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      good(1'b1, i[1], i[0]);
      checks++;
      if (dut_snap() !== exp_snap()) begin
        failures++; $display("FAIL clean_step%0d got=%h exp=%h", i, dut_snap(), exp_snap());
      end
    end
    checks++;
    if ({vec_count, err_count, fail_mask, done, pass, busy} !== {16'd4, 16'd0, 3'b000, 3'b110}) begin
      failures++;
      $display("FAIL clean_final vec=%0d err=%0d mask=%b done=%b pass=%b busy=%b exp 4 0 000 1 1 0",
               vec_count, err_count, fail_mask, done, pass, busy);
    end
  endtask

  task automatic test_single_fault();
    do_reset();
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    good(1'b1, 0, 0);
    good(1'b1, 0, 1);
    cyc(1'b0, 1'b1, 1, 0, 0, 1, 0);
    good(1'b1, 1, 1);
    checks++;
    if ({err_count, fail_mask, first_fail_idx, first_fail_vec, pass, done} !==
        {16'd1, 3'b001, 16'd2, 5'b10010, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_fault err=%0d mask=%b ffi=%0d ffv=%b pass=%b done=%b exp 1 001 2 10010 0 1",
               err_count, fail_mask, first_fail_idx, first_fail_vec, pass, done);
    end
  endtask

  task automatic test_multi_fault();
    do_reset();
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    good(1'b1, 0, 0);
    cyc(1'b0, 1'b1, 0, 1, 1, 1, 1);
    good(1'b1, 1, 0);
    cyc(1'b0, 1'b1, 1, 1, 1, 0, 0);
    checks++;
    if ({err_count, fail_mask, first_fail_idx, first_fail_vec, pass} !==
        {16'd2, 3'b110, 16'd1, 5'b01111, 1'b0}) begin
      failures++;
      $display("FAIL multi_fault err=%0d mask=%b ffi=%0d ffv=%b pass=%b exp 2 110 1 01111 0",
               err_count, fail_mask, first_fail_idx, first_fail_vec, pass);
    end
  endtask

  task automatic test_control_edges();
    do_reset();
    good(1'b1, 1, 1);
    checks++;
    if (vec_count !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_valid_ignored vec=%0d busy=%b exp 0 0", vec_count, busy);
    end
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    good(1'b1, 0, 0);
    cyc(1'b1, 1'b1, 0, 1, 0, 1, 1);
    checks++;
    if (vec_count !== 16'd2) begin
      failures++; $display("FAIL start_in_run vec=%0d exp 2", vec_count);
    end
    good(1'b0, 1, 1);
    good(1'b0, 1, 1);
    checks++;
    if (vec_count !== 16'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL valid_gap vec=%0d busy=%b exp 2 1", vec_count, busy);
    end
    good(1'b1, 1, 0);
    cyc(1'b0, 1'b1, 1, 1, 0, 0, 0);
    checks++;
    if (dut_snap() !== exp_snap() || done !== 1'b1) begin
      failures++; $display("FAIL edge_done got=%h exp=%h", dut_snap(), exp_snap());
    end
    cyc(1'b0, 1'b1, 1, 1, 0, 0, 0);
    checks++;
    if (dut_snap() !== exp_snap() || vec_count !== 16'd4 || err_count !== 16'd1) begin
      failures++; $display("FAIL done_valid_ignored got=%h exp=%h", dut_snap(), exp_snap());
    end
    cyc(1'b1, 1'b1, 1, 1, 0, 0, 0);
    checks++;
    if ({vec_count, err_count, fail_mask, busy, done} !== {16'd0, 16'd0, 3'b000, 2'b10}) begin
      failures++;
      $display("FAIL restart_from_done vec=%0d err=%0d mask=%b busy=%b done=%b exp 0 0 000 1 0",
               vec_count, err_count, fail_mask, busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 0, 0, 1, 0, 0);
    good(1'b1, 0, 1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    model_clear(); m_run = 0; m_done = 0;
    #1;
    checks++;
    if (dut_snap() !== '0) begin
      failures++; $display("FAIL midrun_reset got=%h exp=0", dut_snap());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) good(1'b1, i[0], i[1]);
    checks++;
    if (dut_snap() !== exp_snap() || pass !== 1'b1 || vec_count !== 16'd4) begin
      failures++; $display("FAIL fresh_run got=%h exp=%h", dut_snap(), exp_snap());
    end
  endtask

  task automatic test_random();
    int budget;
    bit ia, ib;
    bit [2:0] flip;
    do_reset();
    for (int run = 0; run < 8; run++) begin
      cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
      budget = 0;
      while (m_run && budget < 80) begin
        ia = 1'($urandom); ib = 1'($urandom);
        flip = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7), ia, ib,
            (ia & ib) ^ flip[2], (ia | ib) ^ flip[1], (ia ^ ib) ^ flip[0]);
        checks++;
        if (dut_snap() !== exp_snap()) begin
          failures++;
          $display("FAIL random_run%0d_cyc%0d got=%h exp=%h", run, budget, dut_snap(), exp_snap());
        end
        budget++;
      end
      checks++;
      if (m_run) begin
        failures++; $display("FAIL random_run%0d_timeout got=busy exp=done", run);
      end
      repeat ($urandom_range(0, 2)) good(1'b1, 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_multi_fault();
    test_control_edges();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
